// File: rtl/sdram_addr_manager.sv
// Circular-buffer address manager for the SDRAM science store: write/read pointers, BA/ROW/COL
// mapping, fill level and flags. Optional stats outputs enabled by SDRAM_ADDR_MGR_STATS_EN.
`timescale 1ns/1ps
module sdram_addr_manager #(
   parameter int unsigned ADDR_W    = 24,
   parameter bit          OVERWRITE = 1'b0,
   parameter int unsigned AF_MARGIN = 64
) (
   input  logic              clk_48mhz,
   input  logic              reset_n,
   input  logic              clear,
   input  logic              next_write,
   input  logic              next_read,
   output logic [1:0]        ba_write,
   output logic [12:0]       row_write,
   output logic [8:0]        col_write,
   output logic [1:0]        ba_read,
   output logic [12:0]       row_read,
   output logic [8:0]        col_read,
   output logic [ADDR_W:0]   fill_count,
   output logic              empty,
   output logic              full,
   output logic              almost_full,
   output logic              overflow,
   output logic              underflow
`ifdef SDRAM_ADDR_MGR_STATS_EN
   ,
   output logic [15:0]       drop_count,
   output logic [ADDR_W:0]   peak_fill
`endif
);

   localparam logic [ADDR_W:0]   Depth   = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0]   AfLevel = Depth - AF_MARGIN[ADDR_W:0];
   localparam logic [ADDR_W-1:0] PtrOne  = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   CntOne  = {{ADDR_W{1'b0}}, 1'b1};

   logic              nw_q, nr_q;
   logic              wr_evt, rd_evt;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   cnt_d;
   logic              ovf_d, udf_d, drop_evt;
   logic [23:0]       wa, ra;

   assign wr_evt = next_write & ~nw_q;
   assign rd_evt = next_read & ~nr_q;

   // Decisions use the pre-update count; clear wins over any event in the same cycle.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = fill_count;
      ovf_d    = overflow;
      udf_d    = underflow;
      drop_evt = 1'b0;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else if (wr_evt && rd_evt) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
         if (fill_count == '0) begin
            cnt_d = CntOne;
            udf_d = 1'b1;
         end else begin
            rd_ptr_d = rd_ptr_q + PtrOne;
         end
      end else if (wr_evt) begin
         if (fill_count != Depth) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
            cnt_d    = fill_count + CntOne;
         end else begin
            ovf_d    = 1'b1;
            drop_evt = 1'b1;
            if (OVERWRITE) begin
               wr_ptr_d = wr_ptr_q + PtrOne;
               rd_ptr_d = rd_ptr_q + PtrOne;
            end
         end
      end else if (rd_evt) begin
         if (fill_count != '0) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
            cnt_d    = fill_count - CntOne;
         end else begin
            udf_d = 1'b1;
         end
      end
   end

   // Column fastest, then bank, then row.
   always_comb begin
      wa = 24'(wr_ptr_d);
      ra = 24'(rd_ptr_d);
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         nw_q <= 1'b0;
         nr_q <= 1'b0;
      end else begin
         nw_q <= next_write;
         nr_q <= next_read;
      end
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         col_write <= '0;
         ba_write  <= '0;
         row_write <= '0;
         col_read  <= '0;
         ba_read   <= '0;
         row_read  <= '0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         col_write <= wa[8:0];
         ba_write  <= wa[10:9];
         row_write <= wa[23:11];
         col_read  <= ra[8:0];
         ba_read   <= ra[10:9];
         row_read  <= ra[23:11];
      end
   end

   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         fill_count  <= '0;
         empty       <= 1'b1;
         full        <= 1'b0;
         almost_full <= 1'b0;
         overflow    <= 1'b0;
         underflow   <= 1'b0;
      end else begin
         fill_count  <= cnt_d;
         empty       <= (cnt_d == '0);
         full        <= (cnt_d == Depth);
         almost_full <= (cnt_d >= AfLevel);
         overflow    <= ovf_d;
         underflow   <= udf_d;
      end
   end

`ifdef SDRAM_ADDR_MGR_STATS_EN
   always_ff @(posedge clk_48mhz or negedge reset_n) begin
      if (!reset_n) begin
         drop_count <= '0;
         peak_fill  <= '0;
      end else if (clear) begin
         drop_count <= '0;
         peak_fill  <= '0;
      end else begin
         if (drop_evt && (drop_count != 16'hFFFF)) begin
            drop_count <= drop_count + 16'd1;
         end
         if (cnt_d > peak_fill) begin
            peak_fill <= cnt_d;
         end
      end
   end
`endif

endmodule

// File: tb/tb_sdram_addr_manager.sv
// Scoreboard bench for sdram_addr_manager: two instances (drop / overwrite policy) share stimulus.
`timescale 1ns/1ps
module tb_sdram_addr_manager;

   localparam int unsigned AW = 11;

   typedef struct {
      int    dut;
      string name;
      int    wp, rp, cnt;
      bit    e, f, af, ov, uf;
      bit    stats;
      int    dc, pk;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n, clear, nw, nr;

   logic [1:0]  ba_w[2], ba_r[2];
   logic [12:0] row_w[2], row_r[2];
   logic [8:0]  col_w[2], col_r[2];
   logic [AW:0] cnt[2];
   logic        emp[2], ful[2], afl[2], ovf[2], udf[2];
`ifdef SDRAM_ADDR_MGR_STATS_EN
   logic [15:0] dcnt[2];
   logic [AW:0] peak[2];
`endif

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   always #5 clk = ~clk;

   sdram_addr_manager #(.ADDR_W(AW), .OVERWRITE(1'b0), .AF_MARGIN(64)) u_drop (
      .clk_48mhz(clk), .reset_n(reset_n), .clear(clear),
      .next_write(nw), .next_read(nr),
      .ba_write(ba_w[0]), .row_write(row_w[0]), .col_write(col_w[0]),
      .ba_read(ba_r[0]), .row_read(row_r[0]), .col_read(col_r[0]),
      .fill_count(cnt[0]), .empty(emp[0]), .full(ful[0]), .almost_full(afl[0]),
      .overflow(ovf[0]), .underflow(udf[0])
`ifdef SDRAM_ADDR_MGR_STATS_EN
      , .drop_count(dcnt[0]), .peak_fill(peak[0])
`endif
   );

   sdram_addr_manager #(.ADDR_W(AW), .OVERWRITE(1'b1), .AF_MARGIN(64)) u_ovw (
      .clk_48mhz(clk), .reset_n(reset_n), .clear(clear),
      .next_write(nw), .next_read(nr),
      .ba_write(ba_w[1]), .row_write(row_w[1]), .col_write(col_w[1]),
      .ba_read(ba_r[1]), .row_read(row_r[1]), .col_read(col_r[1]),
      .fill_count(cnt[1]), .empty(emp[1]), .full(ful[1]), .almost_full(afl[1]),
      .overflow(ovf[1]), .underflow(udf[1])
`ifdef SDRAM_ADDR_MGR_STATS_EN
      , .drop_count(dcnt[1]), .peak_fill(peak[1])
`endif
   );

   // Expected {BA, ROW, COL} for a linear word pointer.
   function automatic logic [23:0] amap(input int p);
      logic [23:0] v;
      v = p[23:0];
      return {v[10:9], v[23:11], v[8:0]};
   endfunction

   // Monitor: one expectation checked per falling edge.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t        x;
         logic [64:0] act, req;
         int          d;
         x   = q.pop_front();
         d   = x.dut;
         act = {ba_w[d], row_w[d], col_w[d], ba_r[d], row_r[d], col_r[d], cnt[d],
                emp[d], ful[d], afl[d], ovf[d], udf[d]};
         req = {amap(x.wp), amap(x.rp), x.cnt[AW:0], x.e, x.f, x.af, x.ov, x.uf};
         n_cmp++;
         if (act !== req) begin
            n_bad++;
            $display("FAIL %s dut%0d: got wa/ra/cnt/flags=%h/%h/%0d/%b required %h/%h/%0d/%b",
                     x.name, d, act[64:41], act[40:17], act[16:5], act[4:0],
                     req[64:41], req[40:17], req[16:5], req[4:0]);
         end
`ifdef SDRAM_ADDR_MGR_STATS_EN
         if (x.stats) begin
            n_cmp++;
            if (dcnt[d] !== x.dc[15:0] || peak[d] !== x.pk[AW:0]) begin
               n_bad++;
               $display("FAIL %s_stats dut%0d: got drop=%0d peak=%0d required drop=%0d peak=%0d",
                        x.name, d, dcnt[d], peak[d], x.dc, x.pk);
            end
         end
`endif
      end
   end

   task automatic chk(input int dut, input string name, input int wp, input int rp, input int c,
                      input bit e, input bit f, input bit af, input bit ov, input bit uf,
                      input bit st = 1'b0, input int dc = 0, input int pk = 0);
      exp_t x;
      x = '{dut, name, wp, rp, c, e, f, af, ov, uf, st, dc, pk};
      q.push_back(x);
      @(posedge clk); #1;
   endtask

   task automatic chk2(input string name, input int wp, input int rp, input int c,
                       input bit e, input bit f, input bit af, input bit ov, input bit uf);
      chk(0, name, wp, rp, c, e, f, af, ov, uf);
      chk(1, name, wp, rp, c, e, f, af, ov, uf);
   endtask

   task automatic wpulse(input int n);
      for (int i = 0; i < n; i++) begin
         nw = 1'b1; @(posedge clk); #1;
         nw = 1'b0; @(posedge clk); #1;
      end
   endtask

   task automatic rpulse(input int n);
      for (int i = 0; i < n; i++) begin
         nr = 1'b1; @(posedge clk); #1;
         nr = 1'b0; @(posedge clk); #1;
      end
   endtask

   task automatic bpulse();
      nw = 1'b1; nr = 1'b1; @(posedge clk); #1;
      nw = 1'b0; nr = 1'b0; @(posedge clk); #1;
   endtask

   task automatic clr();
      clear = 1'b1; @(posedge clk); #1;
      clear = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout required summary before 1ms");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n = 1'b0; clear = 1'b0; nw = 1'b0; nr = 1'b0;
      @(posedge clk); #1;
      chk(0, "reset", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      chk(1, "reset", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      wpulse(3);
      chk2("wr3", 3, 0, 3, 0, 0, 0, 0, 0);
      rpulse(3);
      chk2("rd3", 3, 3, 0, 1, 0, 0, 0, 0);
      clr();
      chk2("clr", 0, 0, 0, 1, 0, 0, 0, 0);

      wpulse(512);
      chk2("w512", 512, 0, 512, 0, 0, 0, 0, 0);
      wpulse(1535);
      chk2("w2047", 2047, 0, 2047, 0, 0, 1, 0, 0);
      wpulse(1);
      chk2("w2048", 0, 0, 2048, 0, 1, 1, 0, 0);

      wpulse(1);
      chk(0, "full_drop", 0, 0, 2048, 0, 1, 1, 1, 0, 1, 1, 2048);
      chk(1, "full_ovw", 1, 1, 2048, 0, 1, 1, 1, 0, 1, 1, 2048);
      rpulse(1);
      chk(0, "rd_after_full", 0, 1, 2047, 0, 0, 1, 1, 0);
      chk(1, "rd_after_full", 1, 2, 2047, 0, 0, 1, 1, 0);
      bpulse();
      chk(0, "both_2047", 1, 2, 2047, 0, 0, 1, 1, 0);
      chk(1, "both_2047", 2, 3, 2047, 0, 0, 1, 1, 0);

      // Clear with a concurrent write edge, strobe then held high.
      clear = 1'b1; nw = 1'b1; @(posedge clk); #1;
      clear = 1'b0;
      repeat (9) @(posedge clk);
      #1;
      chk(0, "clr_hold", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      chk(1, "clr_hold", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0);
      nw = 1'b0; @(posedge clk); #1;

      nw = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      nw = 1'b0; @(posedge clk); #1;
      chk2("held10", 1, 0, 1, 0, 0, 0, 0, 0);
      rpulse(1);
      chk2("rd1", 1, 1, 0, 1, 0, 0, 0, 0);
      rpulse(1);
      chk2("udf", 1, 1, 0, 1, 0, 0, 0, 1);

      clr();
      bpulse();
      chk2("both_empty", 1, 0, 1, 0, 0, 0, 0, 1);
      clr();
      wpulse(5);
      bpulse();
      chk2("both_5", 6, 1, 5, 0, 0, 0, 0, 0);

      // Reset asserted between clock edges; checked before the next rising edge.
      nw = 1'b1;
      reset_n = 1'b0;
      chk2("async_rst", 0, 0, 0, 1, 0, 0, 0, 0);
      nw = 1'b0;
      reset_n = 1'b1;

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      if (q.size() > 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending required 0", q.size());
      end
      #20;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
